// File: rtl/bcd_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD conversion arbiter.
package bcd_pkg;

  localparam int DATA_W  = 20;
  localparam int DIGITS  = 6;
  localparam int BCD_W   = 24;
  localparam int SHIFT_W = 44;
  localparam logic [DATA_W-1:0] MAX_DEC   = 20'd999999;
  localparam logic [4:0]        LAST_ITER = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One shift-and-add-3 step; the hundred-thousands nibble is left in plain binary.
  function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] sr);
    logic [SHIFT_W-1:0] adj;
    adj = sr;
    for (int d = 0; d < DIGITS - 1; d++) begin
      if (adj[DATA_W + 4*d +: 4] > 4'd4) begin
        adj[DATA_W + 4*d +: 4] = adj[DATA_W + 4*d +: 4] + 4'd3;
      end else begin
        adj[DATA_W + 4*d +: 4] = adj[DATA_W + 4*d +: 4];
      end
    end
    return {adj[SHIFT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// Requester-side bus of the BCD conversion arbiter: requests, operands, acknowledge and result.
interface bcd_convert_arbiter_if #(
  parameter int N_REQ = 4
);
  import bcd_pkg::*;

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [DATA_W*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]        ack;
  logic [BCD_W-1:0]        bcd_out;
  logic                    ovf;
  logic                    busy;
  logic [ID_W-1:0]         grant_id;

  modport master (
    output req, data_in,
    input  ack, bcd_out, ovf, busy, grant_id
  );

  modport slave (
    input  req, data_in,
    output ack, bcd_out, ovf, busy, grant_id
  );

endinterface

// File: rtl/bcd_convert_arbiter_shift_core.sv
// Sequential 20-iteration shift-and-add-3 core: load on start, done flags the final iteration.
module bcd_shift_core
  import bcd_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] operand,
  output logic              done,
  output logic [BCD_W-1:0]  result
);

  logic [SHIFT_W-1:0] shift_r;
  logic [SHIFT_W-1:0] shift_next_s;
  logic [4:0]         iter_r;
  logic               active_r;

  assign shift_next_s = dabble_step(shift_r);
  assign done         = active_r && (iter_r == LAST_ITER);
  // Result is taken from the post-iteration value so the owner can register it on the final edge.
  assign result       = shift_next_s[SHIFT_W-1 -: BCD_W];

  // Shift register, iteration counter and run flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_r  <= {SHIFT_W{1'b0}};
      iter_r   <= 5'd0;
      active_r <= 1'b0;
    end else if (start) begin
      shift_r  <= {{BCD_W{1'b0}}, operand};
      iter_r   <= 5'd0;
      active_r <= 1'b1;
    end else if (active_r) begin
      shift_r <= shift_next_s;
      if (iter_r == LAST_ITER) begin
        iter_r   <= 5'd0;
        active_r <= 1'b0;
      end else begin
        iter_r <= iter_r + 5'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one bcd_shift_core among N_REQ requesters.
// Optional BCD_ARB_OVERRANGE_EN clamps operands above 999999 to 999999 and raises ovf.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ = 4
)(
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  bcd_convert_arbiter_if.slave  bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state_r;
  state_t            state_next_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   grant_id_r;
  logic [N_REQ-1:0]  ack_r;
  logic [BCD_W-1:0]  bcd_out_r;
  logic              ovf_r;
  logic              busy_r;

  logic [ID_W-1:0]   winner_s;
  logic              found_s;
  logic              start_s;
  logic [DATA_W-1:0] operand_s;
  logic              core_done_s;
  logic [BCD_W-1:0]  core_result_s;
  logic              ovf_sel_s;
  logic [N_REQ-1:0]  ack_onehot_s;

  // Round-robin search starting at ptr and wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = {ID_W{1'b0}};
    for (int off = 0; off < N_REQ; off++) begin
      int idx;
      idx = int'(ptr_r) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && bus.req[idx]) begin
        found_s  = 1'b1;
        winner_s = ID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux for the selected winner.
  always_comb begin
    operand_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_s == ID_W'(i)) begin
        operand_s = bus.data_in[DATA_W*i +: DATA_W];
      end else begin
        operand_s = operand_s;
      end
    end
  end

  // Next-state logic; start fires on the grant edge only.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_next_s = CONV;
          start_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (core_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CONV;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifdef BCD_ARB_OVERRANGE_EN
  logic ovf_pend_r;

  // Overrange is judged on the operand sampled at grant time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_pend_r <= 1'b0;
    end else if (start_s) begin
      ovf_pend_r <= (operand_s > MAX_DEC);
    end
  end

  assign ovf_sel_s = ovf_pend_r;
`else
  assign ovf_sel_s = 1'b0;
`endif

  assign ack_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_r;

  // Grant, result, acknowledge and pointer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_r      <= {ID_W{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
      ack_r      <= {N_REQ{1'b0}};
      bcd_out_r  <= {BCD_W{1'b0}};
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= {N_REQ{1'b0}};
          if (start_s) begin
            grant_id_r <= winner_s;
            busy_r     <= 1'b1;
          end
        end
        CONV: begin
          if (core_done_s) begin
            bcd_out_r <= ovf_sel_s ? 24'h999999 : core_result_s;
            ovf_r     <= ovf_sel_s;
            ack_r     <= ack_onehot_s;
          end else begin
            ack_r <= {N_REQ{1'b0}};
          end
        end
        DONE: begin
          ack_r  <= {N_REQ{1'b0}};
          busy_r <= 1'b0;
          // The just-served requester becomes lowest priority.
          if (grant_id_r == ID_W'(N_REQ-1)) begin
            ptr_r <= {ID_W{1'b0}};
          end else begin
            ptr_r <= grant_id_r + ID_W'(1);
          end
        end
        default: begin
          ack_r  <= {N_REQ{1'b0}};
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  bcd_shift_core u_core (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start_s),
    .operand   (operand_s),
    .done      (core_done_s),
    .result    (core_result_s)
  );

  assign bus.ack      = ack_r;
  assign bus.bcd_out  = bcd_out_r;
  assign bus.ovf      = ovf_r;
  assign bus.busy     = busy_r;
  assign bus.grant_id = grant_id_r;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard testbench for bcd_convert_arbiter with four requesters.
module tb_bcd_convert_arbiter;

  logic sys_clk;
  logic sys_rst_n;

  bcd_convert_arbiter_if #(.N_REQ(4)) bus ();

  bcd_convert_arbiter #(.N_REQ(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  ack;
    logic [23:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Decimal reference; top digit may reach 10 and is kept as a raw nibble.
  function automatic exp_t model(input int id, input int value);
    exp_t e;
    int   v;
    e.ack = 4'b0001 << id;
    e.ovf = 1'b0;
    v = value;
`ifdef BCD_ARB_OVERRANGE_EN
    if (value > 999999) begin
      v     = 999999;
      e.ovf = 1'b1;
    end
`endif
    e.bcd = 24'h0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[4*d +: 4] = 4'((v / (10 ** d)) % 10);
    end
    e.bcd[23:20] = 4'(v / 100000);
    return e;
  endfunction

  function automatic exp_t sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      e.ack = 4'b1111;
      e.bcd = 24'hFFFFFF;
      e.ovf = 1'b1;
    end else begin
      e = sb_q.pop_front();
    end
    return e;
  endfunction

  task automatic issue(input int id, input int value);
    bus.data_in[20*id +: 20] = 20'(value);
    bus.req[id] = 1'b1;
    sb_q.push_back(model(id, value));
  endtask

  task automatic wait_ack(input int limit, input logic [3:0] keep,
                          output logic [3:0] a, output int cyc);
    a   = 4'b0000;
    cyc = 0;
    while (cyc < limit && a == 4'b0000) begin
      @(negedge sys_clk);
      cyc++;
      if (bus.ack != 4'b0000) a = bus.ack;
    end
    if (a != 4'b0000) bus.req = bus.req & ~(a & ~keep);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ack, bus.bcd_out, bus.ovf, bus.busy, bus.grant_id} !== 33'd0) begin
      errors++;
      $display("FAIL reset_state got ack=%b bcd=%h ovf=%b busy=%b gid=%0d want all zero",
               bus.ack, bus.bcd_out, bus.ovf, bus.busy, bus.grant_id);
    end
  endtask

  task automatic test_single();
    logic [3:0] a;
    int         cyc;
    exp_t       e;
    issue(0, 123456);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_busy got busy=%b gid=%0d want busy=1 gid=0", bus.busy, bus.grant_id);
    end
    bus.data_in[19:0] = 20'd654321;
    wait_ack(60, 4'b0000, a, cyc);
    cyc = cyc + 3;
    e = sb_pop();
    checks++;
    if (a !== e.ack || bus.bcd_out !== e.bcd || bus.ovf !== e.ovf || cyc != 21) begin
      errors++;
      $display("FAIL single got ack=%b bcd=%h ovf=%b lat=%0d want ack=%b bcd=%h ovf=%b lat=21",
               a, bus.bcd_out, bus.ovf, cyc, e.ack, e.bcd, e.ovf);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.bcd_out !== 24'h123456) begin
      errors++;
      $display("FAIL single_after got ack=%b busy=%b bcd=%h want ack=0000 busy=0 bcd=123456",
               bus.ack, bus.busy, bus.bcd_out);
    end
  endtask

  task automatic test_boundaries();
    int         ids  [3] = '{1, 2, 3};
    int         vals [3] = '{0, 999999, 9};
    logic [3:0] a;
    int         cyc;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      issue(ids[i], vals[i]);
      wait_ack(60, 4'b0000, a, cyc);
      e = sb_pop();
      checks++;
      if (a !== e.ack || bus.bcd_out !== e.bcd || bus.ovf !== e.ovf || cyc != 21) begin
        errors++;
        $display("FAIL boundary_%0d got ack=%b bcd=%h ovf=%b lat=%0d want ack=%b bcd=%h ovf=%b lat=21",
                 vals[i], a, bus.bcd_out, bus.ovf, cyc, e.ack, e.bcd, e.ovf);
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_overrange();
    logic [3:0]  a;
    int          cyc;
    exp_t        e;
    logic [23:0] want_bcd;
    logic        want_ovf;
`ifdef BCD_ARB_OVERRANGE_EN
    want_bcd = 24'h999999;
    want_ovf = 1'b1;
`else
    want_bcd = 24'hA48575;
    want_ovf = 1'b0;
`endif
    issue(1, 1048575);
    wait_ack(60, 4'b0000, a, cyc);
    e = sb_pop();
    checks++;
    if (a !== e.ack || bus.bcd_out !== want_bcd || bus.bcd_out !== e.bcd || bus.ovf !== want_ovf) begin
      errors++;
      $display("FAIL overrange got ack=%b bcd=%h ovf=%b want ack=%b bcd=%h ovf=%b",
               a, bus.bcd_out, bus.ovf, e.ack, want_bcd, want_ovf);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0] a;
    int         cyc;
    exp_t       e;
    bus.data_in[40 +: 20] = 20'd777777;
    bus.req[2] = 1'b1;
    repeat (11) @(negedge sys_clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL midconv_busy got busy=%b gid=%0d want busy=1 gid=2", bus.busy, bus.grant_id);
    end
    sys_rst_n = 1'b0;
    bus.req   = 4'b0000;
    #1;
    checks++;
    if ({bus.ack, bus.bcd_out, bus.ovf, bus.busy, bus.grant_id} !== 33'd0) begin
      errors++;
      $display("FAIL midconv_reset got ack=%b bcd=%h ovf=%b busy=%b gid=%0d want all zero",
               bus.ack, bus.bcd_out, bus.ovf, bus.busy, bus.grant_id);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_ack(30, 4'b0000, a, cyc);
    checks++;
    if (a !== 4'b0000) begin
      errors++;
      $display("FAIL midconv_noack got ack=%b want 0000", a);
    end
    // With ptr back at 0, requester 1 beats requester 3.
    issue(1, 314159);
    issue(3, 271828);
    for (int k = 0; k < 2; k++) begin
      wait_ack(60, 4'b0000, a, cyc);
      e = sb_pop();
      checks++;
      if (a !== e.ack || bus.bcd_out !== e.bcd || bus.ovf !== e.ovf || cyc != (k == 0 ? 21 : 22)) begin
        errors++;
        $display("FAIL postreset_%0d got ack=%b bcd=%h ovf=%b lat=%0d want ack=%b bcd=%h ovf=%b",
                 k, a, bus.bcd_out, bus.ovf, cyc, e.ack, e.bcd, e.ovf);
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    int         cyc;
    exp_t       e;
    for (int i = 0; i < 4; i++) issue(i, 11 * (i + 1));
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, 4'b0000, a, cyc);
      e = sb_pop();
      checks++;
      if (a !== e.ack || bus.bcd_out !== e.bcd || bus.ovf !== e.ovf || cyc != (k == 0 ? 21 : 22)) begin
        errors++;
        $display("FAIL b2b_%0d got ack=%b bcd=%h lat=%0d want ack=%b bcd=%h lat=%0d",
                 k, a, bus.bcd_out, cyc, e.ack, e.bcd, (k == 0 ? 21 : 22));
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_hold_req();
    logic [3:0] a;
    int         cyc;
    exp_t       e;
    logic [3:0] keep [3] = '{4'b0010, 4'b0000, 4'b0000};
    issue(1, 555);
    issue(2, 666);
    sb_q.push_back(model(1, 555));
    for (int k = 0; k < 3; k++) begin
      wait_ack(60, keep[k], a, cyc);
      e = sb_pop();
      checks++;
      if (a !== e.ack || bus.bcd_out !== e.bcd || cyc != (k == 0 ? 21 : 22)) begin
        errors++;
        $display("FAIL hold_%0d got ack=%b bcd=%h lat=%0d want ack=%b bcd=%h",
                 k, a, bus.bcd_out, cyc, e.ack, e.bcd);
      end
    end
    @(negedge sys_clk);
    checks++;
    if (sb_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain got pending=%0d busy=%b want pending=0 busy=0", sb_q.size(), bus.busy);
    end
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    bus.req     = 4'b0000;
    bus.data_in = 80'd0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_boundaries();
    test_overrange();
    test_reset_mid_conv();
    test_back_to_back();
    test_hold_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
